writeback_queue: RTL

//   Write side of the dual-write-port integer register file. Buffers results from
//   the two execution pipes and drains them in program order, up to two per cycle.

---
 rtl/rv_pkg.sv | 11 +
 rtl/wbq_mask_decode.sv | 21 ++
 rtl/writeback_queue.sv | 107 ++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared integer register-file definitions for the writeback path.
package rv_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int XLEN       = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;
endpackage

// File: rtl/wbq_mask_decode.sv
// Turns the occupied queue entries into a per-register pending-write mask.
module wbq_mask_decode
   import rv_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic [DEPTH-1:0]                 occupied,
   input  logic [DEPTH-1:0][REG_ADDR_W-1:0] rds,
   output logic [NUM_REGS-1:0]              mask
);

   always_comb begin
      mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (occupied[i]) mask[rds[i]] = 1'b1;
      end
      // x0 is never written, so it can never be a hazard
      mask[0] = 1'b0;
   end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback buffer feeding the two register-file write ports,
// draining up to two entries per cycle from the head.
module writeback_queue
   import rv_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int XLEN  = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in0_valid,
   input  logic [4:0]                    in0_rd,
   input  logic [XLEN-1:0]               in0_data,
   input  logic                          in1_valid,
   input  logic [4:0]                    in1_rd,
   input  logic [XLEN-1:0]               in1_data,
   output logic                          in_ready,
   input  logic                          wb_stall,
   output logic                          write1,
   output logic [4:0]                    rd1,
   output logic [XLEN-1:0]               write1_data,
   output logic                          write2,
   output logic [4:0]                    rd2,
   output logic [XLEN-1:0]               write2_data,
   output logic [31:0]                   pending_mask,
   output logic [$clog2(DEPTH):0]        count
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0]                       head, tail, head1, tail1;
   logic [PW:0]                         cnt, npush, npop;
   logic [DEPTH-1:0][REG_ADDR_W-1:0]    rd_mem;
   logic [XLEN-1:0]                     data_mem [DEPTH];
   logic [DEPTH-1:0]                    occupied;
   logic                                push0, push1, pop1, pop2, en1, en2;
   logic [REG_ADDR_W-1:0]               rd_h0, rd_h1;

   assign count    = cnt;
   assign in_ready = (cnt <= (PW+1)'(DEPTH-2));
   assign push0    = in_ready & in0_valid;
   assign push1    = in_ready & in1_valid;
   assign npush    = (PW+1)'(push0) + (PW+1)'(push1);
   assign head1    = head + PW'(1);
   assign tail1    = tail + PW'(1);

   always_comb begin
      npop = '0;
      if (!wb_stall) begin
         if (cnt >= (PW+1)'(2))      npop = (PW+1)'(2);
         else if (cnt == (PW+1)'(1)) npop = (PW+1)'(1);
      end
   end

   assign pop1  = (npop != '0);
   assign pop2  = (npop == (PW+1)'(2));
   assign rd_h0 = rd_mem[head];
   assign rd_h1 = rd_mem[head1];

   // When both slots hit the same register only the younger write survives
   assign en2 = pop2 && (rd_h1 != '0);
   assign en1 = pop1 && (rd_h0 != '0) && !(en2 && (rd_h0 == rd_h1));

   assign write1      = en1;
   assign rd1         = en1 ? rd_h0 : '0;
   assign write1_data = en1 ? data_mem[head] : '0;
   assign write2      = en2;
   assign rd2         = en2 ? rd_h1 : '0;
   assign write2_data = en2 ? data_mem[head1] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         head <= head + npop[PW-1:0];
         tail <= tail + npush[PW-1:0];
         cnt  <= cnt + npush - npop;
      end
   end

   // A lone in1 takes the tail slot; otherwise it lands behind in0
   always_ff @(posedge clk) begin
      if (push0) begin
         rd_mem[tail]   <= in0_rd;
         data_mem[tail] <= in0_data;
      end
      if (push1) begin
         rd_mem[push0 ? tail1 : tail]   <= in1_rd;
         data_mem[push0 ? tail1 : tail] <= in1_data;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         occupied[i] = ({1'b0, PW'(i) - head} < cnt);
      end
   end

   wbq_mask_decode #(.DEPTH(DEPTH)) u_mask (
      .occupied (occupied),
      .rds      (rd_mem),
      .mask     (pending_mask)
   );

endmodule
